round_key_scheduler: RTL and testbench

//  Sequencer and storage for the AES-128 key schedule. Loads a cipher key.

---
 rtl/aes_pkg.sv | 60 ++++++
 rtl/key_expansion.sv | 29 ++
 rtl/round_key_scheduler.sv | 122 ++++++++++++
 tb/tb_round_key_scheduler.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared types, sizes and GF(2^8) helpers for the AES-128 key schedule.
package aes_pkg;

    localparam int REG_SIZE   = 32;
    localparam int VEC_SIZE   = 4;
    localparam int NUM_ROUNDS = 10;
    localparam int NUM_RKEYS  = NUM_ROUNDS + 1;

    typedef logic [3:0][31:0] round_key_t;

    typedef enum logic [1:0] {
        IDLE,
        EXPAND,
        DONE
    } ks_state_t;

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // S-box computed as x^254 (multiplicative inverse, 0 -> 0) followed by the affine map.
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] r;
        logic [7:0] inv;
        r = x;
        for (int i = 0; i < 6; i++) begin
            r = gf_mul(gf_mul(r, r), x);
        end
        inv = gf_mul(r, r);
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] idx);
        logic [7:0] rc;
        case (idx)
            4'd0:    rc = 8'h01;
            4'd1:    rc = 8'h02;
            4'd2:    rc = 8'h04;
            4'd3:    rc = 8'h08;
            4'd4:    rc = 8'h10;
            4'd5:    rc = 8'h20;
            4'd6:    rc = 8'h40;
            4'd7:    rc = 8'h80;
            4'd8:    rc = 8'h1b;
            4'd9:    rc = 8'h36;
            default: rc = 8'h00;
        endcase
        return rc;
    endfunction

endpackage

// File: rtl/key_expansion.sv
// One AES-128 key-schedule round, purely combinational.
module key_expansion
    import aes_pkg::*;
(
    input  logic [VEC_SIZE-1:0][REG_SIZE-1:0] current_key,
    input  logic [3:0]                        round,
    output logic [VEC_SIZE-1:0][REG_SIZE-1:0] next_key
);

    logic [31:0] rot_word;
    logic [31:0] temp;
    logic [31:0] w4;
    logic [31:0] w5;
    logic [31:0] w6;
    logic [31:0] w7;

    always_comb begin
        rot_word = {current_key[3][23:0], current_key[3][31:24]};
        temp     = {sbox(rot_word[31:24]), sbox(rot_word[23:16]),
                    sbox(rot_word[15:8]),  sbox(rot_word[7:0])}
                   ^ {rcon(round), 24'h000000};
        w4       = current_key[0] ^ temp;
        w5       = current_key[1] ^ w4;
        w6       = current_key[2] ^ w5;
        w7       = current_key[3] ^ w6;
        next_key = {w7, w6, w5, w4};
    end

endmodule

// File: rtl/round_key_scheduler.sv
// AES-128 key-schedule sequencer: expands a cipher key into 11 stored round keys
// and serves them by round index with one cycle of read latency.
//
//  state  | meaning
//  IDLE   | no valid keys, waiting for start
//  EXPAND | one expansion round written per cycle
//  DONE   | all round keys valid, reads served, start restarts
module round_key_scheduler
    import aes_pkg::*;
(
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              start,
    input  logic [VEC_SIZE-1:0][REG_SIZE-1:0] key_in,
    output logic                              busy,
    output logic                              done,
    input  logic                              rd_en,
    input  logic [3:0]                        rd_round,
    output logic [VEC_SIZE-1:0][REG_SIZE-1:0] rd_key,
    output logic                              rd_valid,
    output logic                              rd_err
);

    ks_state_t  state;
    ks_state_t  state_nxt;
    logic [3:0] cnt;
    logic [3:0] cnt_nxt;
    logic       busy_nxt;
    logic       done_nxt;
    logic       load;
    logic       wr;
    logic [3:0] round_idx;
    round_key_t work_key;
    round_key_t next_key;
    round_key_t key_buf [NUM_RKEYS];

    assign round_idx = cnt - 4'd1;

    key_expansion u_key_expansion (
        .current_key (work_key),
        .round       (round_idx),
        .next_key    (next_key)
    );

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        busy_nxt  = busy;
        done_nxt  = done;
        load      = 1'b0;
        wr        = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_nxt = EXPAND;
                    cnt_nxt   = 4'd1;
                    busy_nxt  = 1'b1;
                    done_nxt  = 1'b0;
                    load      = 1'b1;
                end
            end
            EXPAND: begin
                wr = 1'b1;
                if (cnt == 4'(NUM_ROUNDS)) begin
                    state_nxt = DONE;
                    busy_nxt  = 1'b0;
                    done_nxt  = 1'b1;
                end else begin
                    cnt_nxt = cnt + 4'd1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= 4'd0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            busy  <= busy_nxt;
            done  <= done_nxt;
        end
    end

    // Key storage is deliberately not reset; done gates every read.
    always_ff @(posedge clk) begin
        if (load) begin
            key_buf[0] <= key_in;
            work_key   <= key_in;
        end else if (wr) begin
            key_buf[cnt] <= next_key;
            work_key     <= next_key;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_key   <= '0;
            rd_valid <= 1'b0;
            rd_err   <= 1'b0;
        end else if (rd_en) begin
            if (done && (rd_round <= 4'(NUM_ROUNDS))) begin
                rd_key   <= key_buf[rd_round];
                rd_valid <= 1'b1;
                rd_err   <= 1'b0;
            end else begin
                rd_key   <= '0;
                rd_valid <= 1'b0;
                rd_err   <= 1'b1;
            end
        end else begin
            rd_valid <= 1'b0;
            rd_err   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_round_key_scheduler.sv
// Self-checking bench for round_key_scheduler: word-array key-schedule model plus FIPS-197 literals.
module tb_round_key_scheduler;

    logic                clk = 1'b0;
    logic                rst;
    logic                start;
    logic [3:0][31:0]    key_in;
    logic                busy;
    logic                done;
    logic                rd_en;
    logic [3:0]          rd_round;
    logic [3:0][31:0]    rd_key;
    logic                rd_valid;
    logic                rd_err;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0]   sb [256];
    logic [127:0] m_keys [11];
    logic         m_busy, m_done, chk_en = 1'b0;
    int           m_left;
    logic [127:0] e_key;
    logic         e_valid, e_err;

    always #5 clk = ~clk;

    round_key_scheduler dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .key_in   (key_in),
        .busy     (busy),
        .done     (done),
        .rd_en    (rd_en),
        .rd_round (rd_round),
        .rd_key   (rd_key),
        .rd_valid (rd_valid),
        .rd_err   (rd_err)
    );

    function automatic logic [127:0] mk(input logic [31:0] w0, input logic [31:0] w1,
                                        input logic [31:0] w2, input logic [31:0] w3);
        return {w3, w2, w1, w0};
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // S-box table built by walking the multiplicative group with generator 3.
    task automatic build_sbox();
        logic [7:0] p, q, x;
        p = 8'h01;
        q = 8'h01;
        do begin
            p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
            q = q ^ (q << 1);
            q = q ^ (q << 2);
            q = q ^ (q << 4);
            if (q[7]) q = q ^ 8'h09;
            x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
            sb[p] = x ^ 8'h63;
        end while (p != 8'h01);
        sb[0] = 8'h63;
    endtask

    // Textbook word-by-word expansion into w[0..43].
    task automatic model_expand(input logic [127:0] key);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[32*i +: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]} ^ {rc, 24'h0};
                rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 11; r++) m_keys[r] = mk(w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]);
    endtask

    always @(posedge clk) begin
        if (rst) begin
            m_busy  = 1'b0;
            m_done  = 1'b0;
            m_left  = 0;
            e_key   = '0;
            e_valid = 1'b0;
            e_err   = 1'b0;
            chk_en  = 1'b1;
        end else begin
            if (rd_en) begin
                if (m_done && rd_round <= 4'd10) begin
                    e_key   = m_keys[rd_round];
                    e_valid = 1'b1;
                    e_err   = 1'b0;
                end else begin
                    e_key   = '0;
                    e_valid = 1'b0;
                    e_err   = 1'b1;
                end
            end else begin
                e_valid = 1'b0;
                e_err   = 1'b0;
            end
            if (m_busy) begin
                m_left--;
                if (m_left == 0) begin
                    m_busy = 1'b0;
                    m_done = 1'b1;
                end
            end else if (start) begin
                model_expand(key_in);
                m_busy = 1'b1;
                m_left = 10;
                m_done = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("busy", {127'd0, busy}, {127'd0, m_busy});
            check("done", {127'd0, done}, {127'd0, m_done});
            check("rd_valid", {127'd0, rd_valid}, {127'd0, e_valid});
            check("rd_err", {127'd0, rd_err}, {127'd0, e_err});
            check("rd_key", rd_key, e_key);
        end
    end

    task automatic wait_done(output int cyc, output int nbusy);
        cyc   = 1;
        nbusy = busy ? 1 : 0;
        while (!done && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (busy) nbusy++;
        end
        if (!done) begin
            n_checks++;
            n_errors++;
            $display("FAIL wait_done: done not seen after %0d cycles", cyc);
        end
    endtask

    task automatic pulse_start(input logic [127:0] k);
        key_in = k;
        start  = 1'b1;
        @(negedge clk);
        start  = 1'b0;
    endtask

    task automatic do_read(input logic [3:0] r);
        rd_en    = 1'b1;
        rd_round = r;
        @(negedge clk);
        rd_en    = 1'b0;
    endtask

    localparam logic [127:0] FIPS_KEY = {32'h09cf4f3c, 32'habf71588, 32'h28aed2a6, 32'h2b7e1516};
    localparam logic [127:0] FIPS_R1  = {32'h2a6c7605, 32'h23a33939, 32'h88542cb1, 32'ha0fafe17};
    localparam logic [127:0] FIPS_R10 = {32'hb6630ca6, 32'he13f0cc8, 32'hc9ee2589, 32'hd014f9a8};
    localparam logic [127:0] ZERO_R10 = {32'h6f8f188e, 32'h23e951cf, 32'h3e92e211, 32'hb4ef5bcb};

    initial begin
        int cyc, nbusy;
        build_sbox();
        rst      = 1'b1;
        start    = 1'b0;
        rd_en    = 1'b0;
        rd_round = 4'd0;
        key_in   = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("reset_busy", {127'd0, busy}, 128'd0);
        check("reset_done", {127'd0, done}, 128'd0);
        check("reset_rd_key", rd_key, 128'd0);

        // Test 1: FIPS-197 expansion and timing
        pulse_start(FIPS_KEY);
        wait_done(cyc, nbusy);
        check("done_latency", cyc, 128'd11);
        check("busy_cycles", nbusy, 128'd10);
        check("model_r1", m_keys[1], FIPS_R1);
        check("model_r10", m_keys[10], FIPS_R10);

        // Tests 2/3: back-to-back reads
        rd_en = 1'b1; rd_round = 4'd1;
        @(negedge clk);
        check("rd_r1", rd_key, FIPS_R1);
        check("rd_r1_valid", {127'd0, rd_valid}, 128'd1);
        rd_round = 4'd10;
        @(negedge clk);
        check("rd_r10", rd_key, FIPS_R10);
        rd_round = 4'd0;
        @(negedge clk);
        check("rd_r0", rd_key, FIPS_KEY);
        rd_en = 1'b0;
        @(negedge clk);
        check("rd_hold", rd_key, FIPS_KEY);

        // Test 4: out-of-range index
        do_read(4'd11);
        check("rd_bad_err", {127'd0, rd_err}, 128'd1);
        check("rd_bad_key", rd_key, 128'd0);
        do_read(4'd15);

        // Test 5: restart, start re-pulsed mid-expansion is ignored, read during EXPAND rejected
        pulse_start(FIPS_KEY);
        repeat (3) @(negedge clk);
        pulse_start('0);
        do_read(4'd2);
        check("rd_expand_err", {127'd0, rd_err}, 128'd1);
        wait_done(cyc, nbusy);
        do_read(4'd1);
        check("rd_r1_again", rd_key, FIPS_R1);
        do_read(4'd10);
        check("rd_r10_again", rd_key, FIPS_R10);

        // Start in DONE with a simultaneous read: read served from the old keys
        rd_en = 1'b1; rd_round = 4'd0;
        pulse_start('0);
        rd_en = 1'b0;
        check("rd_with_start", rd_key, FIPS_KEY);
        check("done_drop", {127'd0, done}, 128'd0);
        wait_done(cyc, nbusy);
        do_read(4'd10);
        check("rd_zero_r10", rd_key, ZERO_R10);

        // Test 6: reset mid-expansion
        pulse_start(FIPS_KEY);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_busy", {127'd0, busy}, 128'd0);
        check("rst_done", {127'd0, done}, 128'd0);
        repeat (12) @(negedge clk);
        do_read(4'd3);
        check("rst_rd_err", {127'd0, rd_err}, 128'd1);
        pulse_start(FIPS_KEY);
        wait_done(cyc, nbusy);
        check("rst_latency", cyc, 128'd11);
        do_read(4'd10);
        check("rd_after_rst", rd_key, FIPS_R10);
        repeat (2) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
